// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode values, FSM
// state encoding and the golden ALU model used by the optional checker.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  // Queued command layout: {op, b, a}; the low byte is the ALU operand byte.
  localparam int ENTRY_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  function automatic logic [7:0] alu_golden(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [2:0] op);
    logic [7:0] za;
    logic [7:0] zb;
    logic [7:0] r;
    za = {4'h0, a};
    zb = {4'h0, b};
    case (op)
      OP_ADD:  r = za + zb;
      OP_SUB:  r = za - zb;
      OP_AND:  r = za & zb;
      OP_OR:   r = za | zb;
      OP_XOR:  r = za ^ zb;
      OP_NOT:  r = ~za;
      OP_SHR:  r = za >> 1;
      default: r = za << 1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Show-ahead synchronous command FIFO; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Host-side initiator for the 4-bit ALU pins: queues commands, drives the pins,
// samples the result after LAT edges. Optional checker: ALU_SEQ_CHECK_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] alu_ui,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic       err_sticky,
  output logic       busy,
  output logic [7:0] done_cnt
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam int CW    = $clog2(DEPTH) + 1;

  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               sample;
  logic               ack;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({cmd_op, cmd_b, cmd_a}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    sample    = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ack       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pin registers only change on a pop, so they hold steady between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ui   <= '0;
      alu_op   <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_op   <= '0;
      done_cnt <= '0;
    end else begin
      if (pop) begin
        alu_ui <= fifo_dout[7:0];
        alu_op <= fifo_dout[10:8];
        cnt    <= CNT_W'(LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (sample) begin
        rsp_data <= alu_res;
        rsp_op   <= alu_op;
      end
      if (ack) done_cnt <= done_cnt + 8'd1;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (fifo_count != '0) || (state != IDLE);

`ifdef ALU_SEQ_CHECK_EN
  logic [7:0] exp_res;
  logic       mismatch;

  assign exp_res  = alu_golden(alu_ui[3:0], alu_ui[7:4], alu_op);
  assign mismatch = (alu_res != exp_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else if (sample) begin
      rsp_err    <= mismatch;
      err_sticky <= err_sticky | mismatch;
    end
  end
`else
  assign rsp_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a behavioural ALU and a queue
// model of command ordering, capacity and response timing.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
`ifdef ALU_SEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [7:0] alu_ui;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_op;
  logic       rsp_err;
  logic       err_sticky;
  logic       busy;
  logic [7:0] done_cnt;

  int   checks   = 0;
  int   failures = 0;
  logic corrupt  = 1'b0;
  logic s_pushed, s_got, s_err, s_sticky;
  logic [7:0] s_data;
  logic [2:0] s_op;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (op)
      3'd0:    r = ia + ib;
      3'd1:    r = ia - ib + 256;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = ia ^ ib;
      3'd5:    r = 255 - ia;
      3'd6:    r = ia / 2;
      default: r = ia * 2;
    endcase
    return 8'(r % 256);
  endfunction

  function automatic cmd_t mk(input int a, input int b, input int op);
    cmd_t c;
    c.a  = 4'(a);
    c.b  = 4'(b);
    c.op = 3'(op);
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
  endfunction

  // Behavioural ALU on the pins; corrupt forces a wrong result for 1+1.
  assign alu_res = (corrupt && alu_ui == 8'h11 && alu_op == 3'd0) ? 8'h00
                 : ref_alu(alu_ui[3:0], alu_ui[7:4], alu_op);

  alu_op_sequencer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_ui     (alu_ui),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  // One clock: drive at the falling edge, note handshakes, advance a cycle.
  task automatic cycle(input logic v, input cmd_t c, input logic rr);
    cmd_valid = v;
    cmd_a     = c.a;
    cmd_b     = c.b;
    cmd_op    = c.op;
    rsp_ready = rr;
    #1;
    s_pushed = v && cmd_ready;
    s_got    = rsp_valid && rr;
    s_data   = rsp_data;
    s_op     = rsp_op;
    s_err    = rsp_err;
    s_sticky = err_sticky;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; corrupt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({alu_ui, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err, err_sticky, busy, done_cnt} !== '0)
      begin failures++; $display("FAIL reset_outputs got=%h want=0",
        {alu_ui, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err, err_sticky, busy, done_cnt}); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int k = 0;
    apply_reset();
    cycle(1'b1, mk(9, 8, 0), 1'b1);
    checks++;
    if (s_pushed !== 1'b1) begin failures++; $display("FAIL add_push got=%b want=1", s_pushed); end
    while (!rsp_valid && k < 20) begin cycle(1'b0, cmd_t'(0), 1'b1); k++; end
    // Registered after edge t+LAT+1, so first seen by the consumer at edge t+LAT+2.
    checks++;
    if (k !== LAT + 1) begin failures++; $display("FAIL add_latency got=%0d want=%0d", k, LAT + 1); end
    checks++;
    if (alu_ui !== 8'h89 || alu_op !== 3'd0) begin
      failures++; $display("FAIL add_pins got=%h/%0d want=89/0", alu_ui, alu_op); end
    checks++;
    if (rsp_data !== 8'h11 || rsp_op !== 3'd0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL add_rsp got=%h/%0d/%b want=11/0/0", rsp_data, rsp_op, rsp_err); end
    cycle(1'b0, cmd_t'(0), 1'b1);
    checks++;
    if (s_got !== 1'b1) begin failures++; $display("FAIL add_handshake got=%b want=1", s_got); end
    checks++;
    if (rsp_valid !== 1'b0 || done_cnt !== 8'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL add_after got=%b/%0d/%b want=0/1/0", rsp_valid, done_cnt, busy); end
  endtask

  task automatic test_sub_not();
    cmd_t c[2];
    logic [7:0] want[2];
    int sent = 0;
    int n = 0;
    apply_reset();
    c[0] = mk(3, 5, 1); c[1] = mk(5, 0, 5);
    want[0] = 8'hFE;    want[1] = 8'hFA;
    for (int cy = 0; cy < 40 && n < 2; cy++) begin
      cycle(sent < 2, c[sent % 2], 1'b1);
      if (s_pushed) sent++;
      if (s_got) begin
        checks++;
        if (s_data !== want[n] || s_op !== c[n].op) begin
          failures++; $display("FAIL sub_not_rsp%0d got=%h/%0d want=%h/%0d", n, s_data, s_op, want[n], c[n].op); end
        n++;
      end
    end
    checks++;
    if (n !== 2) begin failures++; $display("FAIL sub_not_count got=%0d want=2", n); end
  endtask

  task automatic test_throughput();
    cmd_t c[4];
    int stamp[4];
    int sent = 0;
    int n = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) c[i] = rnd_cmd();
    for (int cy = 0; cy < 60 && n < 4; cy++) begin
      cycle(sent < 4, c[sent % 4], 1'b1);
      if (s_pushed) sent++;
      if (s_got) begin
        checks++;
        if (s_data !== ref_alu(c[n].a, c[n].b, c[n].op) || s_op !== c[n].op) begin
          failures++; $display("FAIL tput_rsp%0d got=%h want=%h", n, s_data, ref_alu(c[n].a, c[n].b, c[n].op)); end
        stamp[n] = cy;
        n++;
      end
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL tput_count got=%0d want=4", n); end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (stamp[i] - stamp[i-1] !== LAT + 2) begin
        failures++; $display("FAIL tput_gap%0d got=%0d want=%0d", i, stamp[i] - stamp[i-1], LAT + 2); end
    end
  endtask

  task automatic test_backpressure_full();
    cmd_t c[6];
    int sent = 0;
    int n = 0;
    int extra = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) c[i] = rnd_cmd();
    for (int cy = 0; cy < 20; cy++) begin
      cycle(sent < 6, c[(sent < 6) ? sent : 5], 1'b0);
      if (s_pushed) sent++;
    end
    checks++;
    if (sent !== DEPTH + 1) begin failures++; $display("FAIL bp_accepted got=%0d want=%0d", sent, DEPTH + 1); end
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL bp_stalled got=%b%b%b want=011", cmd_ready, rsp_valid, busy); end
    // Release: the response drains while the queue is still full.
    cycle(1'b1, c[5], 1'b1);
    checks++;
    if (s_got !== 1'b1 || s_pushed !== 1'b0) begin
      failures++; $display("FAIL bp_release got=%b%b want=10", s_got, s_pushed); end
    if (s_got) begin
      checks++;
      if (s_data !== ref_alu(c[0].a, c[0].b, c[0].op)) begin
        failures++; $display("FAIL bp_rsp0 got=%h want=%h", s_data, ref_alu(c[0].a, c[0].b, c[0].op)); end
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle_ready got=%b want=0", cmd_ready); end
    for (int cy = 0; cy < 80 && n < 6; cy++) begin
      cycle(sent < 6, c[(sent < 6) ? sent : 5], 1'b1);
      if (s_pushed) sent++;
      if (s_got) begin
        checks++;
        if (s_data !== ref_alu(c[n].a, c[n].b, c[n].op) || s_op !== c[n].op) begin
          failures++; $display("FAIL bp_rsp%0d got=%h/%0d want=%h/%0d", n, s_data, s_op,
                               ref_alu(c[n].a, c[n].b, c[n].op), c[n].op); end
        n++;
      end
    end
    checks++;
    if (n !== 6 || sent !== 6) begin failures++; $display("FAIL bp_totals got=%0d/%0d want=6/6", n, sent); end
    repeat (10) begin
      cycle(1'b0, cmd_t'(0), 1'b1);
      if (s_got) extra++;
    end
    checks++;
    if (extra !== 0 || done_cnt !== 8'd6) begin
      failures++; $display("FAIL bp_no_dup got=%0d/%0d want=0/6", extra, done_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    int acc = 0;
    int seen = 0;
    apply_reset();
    repeat (3) begin
      cycle(1'b1, rnd_cmd(), 1'b0);
      if (s_pushed) acc++;
    end
    checks++;
    if (acc !== 3 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_wait_setup got=%0d/%b/%b want=3/1/0", acc, busy, rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_ui, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err, err_sticky, busy, done_cnt} !== '0
        || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_wait_outputs got=%h/%b want=0/1",
        {alu_ui, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err, err_sticky, busy, done_cnt}, cmd_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      cycle(1'b0, cmd_t'(0), 1'b1);
      if (s_got || rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || done_cnt !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_wait_after got=%0d/%0d/%b want=0/0/0", seen, done_cnt, busy); end
  endtask

  task automatic test_checker();
    cmd_t c[2];
    logic [7:0] want_d[2];
    logic want_e[2];
    int sent = 0;
    int n = 0;
    apply_reset();
    corrupt = 1'b1;
    c[0] = mk(1, 1, 0);   c[1] = mk(2, 3, 0);
    want_d[0] = 8'h00;    want_d[1] = 8'h05;
    want_e[0] = CHK;      want_e[1] = 1'b0;
    for (int cy = 0; cy < 40 && n < 2; cy++) begin
      cycle(sent < 2, c[sent % 2], 1'b1);
      if (s_pushed) sent++;
      if (s_got) begin
        checks++;
        if (s_data !== want_d[n] || s_err !== want_e[n] || s_sticky !== CHK) begin
          failures++; $display("FAIL chk_rsp%0d got=%h/%b/%b want=%h/%b/%b", n, s_data, s_err, s_sticky,
                               want_d[n], want_e[n], CHK); end
        n++;
      end
    end
    checks++;
    if (n !== 2 || err_sticky !== CHK) begin
      failures++; $display("FAIL chk_sticky got=%0d/%b want=2/%b", n, err_sticky, CHK); end
    corrupt = 1'b0;
  endtask

  task automatic test_random();
    cmd_t c;
    cmd_t e;
    logic v;
    logic rr;
    int done_model = 0;
    int max_out = 0;
    apply_reset();
    for (int cy = 0; cy < 600 + 100; cy++) begin
      if (cy >= 600 && exp_q.size() == 0) break;
      v  = (cy < 600) && ($urandom_range(0, 9) < 6);
      rr = (cy >= 600) || ($urandom_range(0, 1) == 1);
      c  = rnd_cmd();
      cycle(v, c, rr);
      if (s_got) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_unexpected got=%h want=none", s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== ref_alu(e.a, e.b, e.op) || s_op !== e.op || s_err !== 1'b0) begin
            failures++; $display("FAIL rand_rsp%0d got=%h/%0d/%b want=%h/%0d/0", done_model, s_data, s_op,
                                 s_err, ref_alu(e.a, e.b, e.op), e.op); end
        end
        done_model++;
      end
      if (s_pushed) exp_q.push_back(c);
      if (exp_q.size() > max_out) max_out = exp_q.size();
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_drain got=%0d want=0", exp_q.size()); end
    checks++;
    if (max_out > DEPTH + 1) begin failures++; $display("FAIL rand_capacity got=%0d want<=%0d", max_out, DEPTH + 1); end
    checks++;
    if (done_cnt !== 8'(done_model) || busy !== 1'b0) begin
      failures++; $display("FAIL rand_done got=%0d/%b want=%0d/0", done_cnt, busy, 8'(done_model)); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_not();
    test_throughput();
    test_backpressure_full();
    test_reset_mid_wait();
    test_checker();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
